// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Receive-side byte FIFO sitting directly behind the UART receiver. Every
// word the receiver qualifies with its one-cycle rx_valid strobe is stored
// and handed to the consumer, in order, over a valid/ready interface. This
// lets a consumer stall without losing bytes. The block also tracks
// occupancy, raises an almost-full watermark, and keeps a sticky overflow
// flag for bytes that arrive with no space.
//
// Parameters
//   DATA_WIDTH : received word width
//   DEPTH      : number of entries (power of two, >= 2)
//   AF_LEVEL   : almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//
// Ports
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   rx_valid     in   one-cycle strobe: rx_data holds a good frame
//   rx_data      in   received word
//   out_data     out  head-of-FIFO word (first-word fall-through)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer accepts the head when out_valid is high
//   count        out  current occupancy, 0..DEPTH
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_LEVEL
//   overflow     out  sticky: a word was dropped
//   clr_overflow in   one-cycle pulse that clears overflow
module uart_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rx_valid,
  input  logic [DATA_WIDTH-1:0]      rx_data,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Flags are decoded only from the registered count, so there is no
  // combinational path from rx_valid or out_ready to any status output.
  assign out_valid   = (count != '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AF_C);
  assign out_data    = mem[rd_ptr];

  // A full FIFO still accepts a word when the head leaves in the same
  // cycle; otherwise a strobe while full is dropped and flagged.
  always_comb begin
    pop  = out_valid & out_ready;
    push = rx_valid & (~full | pop);
    drop = rx_valid & full & ~pop;
  end

  // Storage is deliberately not reset; the pointers and count define
  // which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop wins over a simultaneous clear so that no lost word goes
  // unreported.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer
// Directed, self-checking bench for uart_rx_buffer with default parameters
// (8-bit data, 16 entries, almost-full at 12). Inputs change 1 ns after a
// rising edge, and outputs are checked in that same settled window.
module tb_uart_rx_buffer;

  logic       clock;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       clr_overflow;

  int compared;
  int mismatched;

  uart_rx_buffer #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .AF_LEVEL(12)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .full(full),
    .almost_full(almost_full),
    .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] drain_exp [16];

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset_n      = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;

    #2;
    check("reset_count",     32'(count),       0);
    check("reset_out_valid", 32'(out_valid),   0);
    check("reset_full",      32'(full),        0);
    check("reset_af",        32'(almost_full), 0);
    check("reset_overflow",  32'(overflow),    0);

    step();
    reset_n = 1'b1;
    step();

    // Two pushes with the consumer stalled, then drain both.
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    step();
    check("first_push_visible", 32'(out_valid), 1);
    rx_data = 8'h3C;
    step();
    rx_valid = 1'b0;
    check("two_count",     32'(count),     2);
    check("two_out_valid", 32'(out_valid), 1);
    check("two_head",      32'(out_data),  32'h A5);
    out_ready = 1'b1;
    step();
    check("pop1_next_head", 32'(out_data), 32'h3C);
    check("pop1_count",     32'(count),    1);
    step();
    out_ready = 1'b0;
    check("pop2_count",     32'(count),     0);
    check("pop2_out_valid", 32'(out_valid), 0);

    // Fill to DEPTH, watching the watermark and full flag.
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(i);
      step();
      check("fill_count", 32'(count),       i + 1);
      check("fill_af",    32'(almost_full), (i + 1 >= 12) ? 1 : 0);
      check("fill_full",  32'(full),        (i + 1 == 16) ? 1 : 0);
    end
    check("fill_no_overflow", 32'(overflow), 0);

    // Push while full with no pop: dropped.
    rx_data = 8'hFF;
    step();
    rx_valid = 1'b0;
    check("drop_overflow", 32'(overflow), 1);
    check("drop_count",    32'(count),    16);
    check("drop_head",     32'(out_data), 32'h00);

    // Drop coincident with clear: overflow stays set.
    rx_valid     = 1'b1;
    rx_data      = 8'hEE;
    clr_overflow = 1'b1;
    step();
    rx_valid = 1'b0;
    check("drop_and_clr_overflow", 32'(overflow), 1);
    step();
    clr_overflow = 1'b0;
    check("clr_alone_overflow", 32'(overflow), 0);
    check("clr_alone_count",    32'(count),    16);

    // Full with simultaneous push and pop: both happen, no overflow.
    rx_valid  = 1'b1;
    rx_data   = 8'h55;
    out_ready = 1'b1;
    step();
    rx_valid  = 1'b0;
    out_ready = 1'b0;
    check("pushpop_full_count",    32'(count),    16);
    check("pushpop_full_overflow", 32'(overflow), 0);
    check("pushpop_full_head",     32'(out_data), 32'h01);

    // Drain: 0x01..0x0F then 0x55; dropped 0xFF/0xEE must not appear.
    for (int i = 0; i < 15; i++) begin
      drain_exp[i] = 8'(i + 1);
    end
    drain_exp[15] = 8'h55;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(out_data), 32'(drain_exp[i]));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty_count", 32'(count),     0);
    check("drain_empty_valid", 32'(out_valid), 0);

    // Streaming push/pop of 40 bytes from 0x10; count never exceeds 1.
    out_ready = 1'b1;
    rx_valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(8'h10 + i);
      if (i > 0) begin
        check("stream_data", 32'(out_data), 32'(8'h10 + i - 1));
      end
      check("stream_count_le1", (count <= 5'd1) ? 32'd1 : 32'd0, 1);
      step();
    end
    rx_valid = 1'b0;
    check("stream_last_data",  32'(out_data), 32'h37);
    check("stream_last_count", 32'(count),    1);
    step();
    out_ready = 1'b0;
    check("stream_end_count", 32'(count), 0);

    // Load five bytes, then reset asynchronously between edges.
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(8'h60 + i);
      step();
    end
    rx_valid = 1'b0;
    check("pre_reset_count", 32'(count), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_count",    32'(count),       0);
    check("async_reset_valid",    32'(out_valid),   0);
    check("async_reset_full",     32'(full),        0);
    check("async_reset_af",       32'(almost_full), 0);
    check("async_reset_overflow", 32'(overflow),    0);
    step();
    reset_n = 1'b1;
    step();
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    step();
    rx_valid = 1'b0;
    check("post_reset_data",  32'(out_data), 32'h77);
    check("post_reset_count", 32'(count),    1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte FIFO directly downstream of the UART receiver FSM/datapath. Captures each byte the receiver qualifies with its one-cycle `rx_valid` strobe and presents bytes in order to the consumer over a valid/ready interface, decoupling the bit-rate receiver from a consumer that may stall. Tracks occupancy, raises an almost-full watermark and a sticky overflow flag when a byte arrives with no space.

## Interface
- `DATA_WIDTH`, default 8: received word width; matches the receiver shift register.
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `AF_LEVEL`, default 12: `almost_full` asserts when count ≥ AF_LEVEL; range 1..DEPTH.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe from the receiver: `rx_data` holds a good frame.
- `rx_data`  in  DATA_WIDTH  received byte, sampled when `rx_valid`=1.
- `out_data`  out  DATA_WIDTH  head-of-FIFO byte (first-word fall-through).
- `out_valid`  out  1  FIFO non-empty; `out_data` valid.
- `out_ready`  in  1  consumer accepts head when `out_valid`=1.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AF_LEVEL.
- `overflow`  out  1  sticky: a byte was dropped.
- `clr_overflow`  in  1  one-cycle pulse clearing `overflow`.

## Operation
- Storage: DEPTH×DATA_WIDTH array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping DEPTH-1 → 0 naturally; separate `count` register is the source of truth for full/empty.
- Push: `rx_valid`=1 and (count < DEPTH, or pop in same cycle) → write `rx_data` at `wr_ptr`, increment `wr_ptr`.
- Pop: `out_valid`=1 and `out_ready`=1 → increment `rd_ptr`.
- Count: +1 push only, −1 pop only, unchanged for both or neither.
- Full with simultaneous push and pop: both happen; count stays DEPTH; no overflow.
- Full with push and no pop: byte dropped, pointers and count unchanged, `overflow` set next edge.
- Empty: `out_ready` ignored; a push into empty FIFO does not bypass to the output in the same cycle.
- `overflow`: set on a drop; cleared by `clr_overflow`; simultaneous drop and clear → stays set.
- `out_data` = mem[`rd_ptr`] combinationally; undefined while `out_valid`=0.
- `full`, `almost_full`, `out_valid` are decoded from registered `count` (no combinational path from `rx_valid` or `out_ready`).
- No internal FSM beyond counters; no reordering, no data modification.

## Timing
- Reset (`reset_n`=0, async, any time including mid-transfer): `wr_ptr`=`rd_ptr`=0, count=0, `out_valid`=0, `full`=0, `almost_full`=0, `overflow`=0; memory contents not reset and stored bytes are discarded.
- Write latency: byte strobed at edge N appears with `out_valid`=1 after edge N (visible cycle N+1).
- Pop takes effect at the edge where `out_valid`&`out_ready`=1; next head visible the following cycle.
- `rx_valid` may be asserted on consecutive cycles; each cycle is a separate push.
- `count`, flags update on the same edge as the push/pop causing them.

## Test plan
- Reset then push 0xA5, 0x3C with `out_ready`=0 → count=2, `out_valid`=1, `out_data`=0xA5; raise `out_ready` for 2 cycles → 0xA5 then 0x3C, count=0, `out_valid`=0.
- Push 16 bytes 0x00..0x0F (DEPTH=16) with `out_ready`=0 → `almost_full` rises when count reaches 12, `full`=1 at 16; push 0xFF → dropped, `overflow`=1, count=16; drain → 0x00..0x0F exactly.
- Full FIFO, push 0x55 with `out_ready`=1 same cycle → head 0x00 popped, 0x55 stored at tail, count=16, `overflow`=0.
- Continuous push/pop for 40 bytes incrementing from 0x10 with `out_ready`=1 → output sequence matches input, pointers wrap twice, count never exceeds 1.
- `overflow`=1, assert `clr_overflow` in same cycle as another drop → `overflow` stays 1; next cycle `clr_overflow` alone → 0.
- Assert `reset_n`=0 with count=5 asynchronously mid-cycle → all outputs immediately at reset values; after release push 0x77 → `out_data`=0x77, count=1.
